// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared size encodings, FSM states and lane constants for the MEM-stage access controller
package mem_ctrl_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;
    localparam int LANE_W = 8;
    localparam int HALF_W = 16;
    localparam logic [LANE_W-1:0] BYTE_MASK = '1;
    localparam logic [HALF_W-1:0] HALF_MASK = '1;
    typedef enum logic [5:0] {
        S_IDLE   = 6'b000001,
        S_RD     = 6'b000010,
        S_WR     = 6'b000100,
        S_RMW_RD = 6'b001000,
        S_RMW_WR = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return (size == 2'b10) || (size == SIZE_HALF && lo[0]) || (size == SIZE_WORD && lo != 2'b00);
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane steering for sub-word load extension and store merge
module mem_lane_align
    import mem_ctrl_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] rd_word,
    input  logic [NB_DATA-1:0] wdata,
    input  logic [1:0]         offset,
    input  logic [1:0]         size,
    input  logic               is_unsigned,
    output logic [NB_DATA-1:0] merged,
    output logic [NB_DATA-1:0] load_ext
);
    logic [4:0]         sh;
    logic [NB_DATA-1:0] mask;
    logic [NB_DATA-1:0] ins;
    logic [NB_DATA-1:0] lane;
    always_comb begin
        sh = (size == SIZE_HALF) ? {offset[1], 4'b0000} : {offset, 3'b000};
        mask = (size == SIZE_BYTE) ? NB_DATA'(BYTE_MASK) << sh :
               (size == SIZE_HALF) ? NB_DATA'(HALF_MASK) << sh : '1;
        ins = wdata << sh;
        merged = (rd_word & ~mask) | (ins & mask);
        // word loads are always offset 0, so the shifted lane is the whole word
        lane = rd_word >> sh;
        load_ext = (size == SIZE_BYTE) ? {{(NB_DATA-LANE_W){~is_unsigned & lane[LANE_W-1]}}, lane[LANE_W-1:0]} :
                   (size == SIZE_HALF) ? {{(NB_DATA-HALF_W){~is_unsigned & lane[HALF_W-1]}}, lane[HALF_W-1:0]} :
                   lane;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a negedge-sampling word memory,
// with sign/zero-extended sub-word loads and read-modify-write sub-word stores.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NB_DATA  = 32,
    parameter int NB_WADDR = 7,
    parameter int NB_BADDR = 32
) (
    input  logic                clock_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    input  logic                req_write_i,
    input  logic [1:0]          req_size_i,
    input  logic                req_unsigned_i,
    input  logic [NB_BADDR-1:0] req_addr_i,
    input  logic [NB_DATA-1:0]  req_wdata_i,
    input  logic [NB_DATA-1:0]  mem_data_i,
    output logic                enable_mem_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic [NB_WADDR-1:0] mem_addr_o,
    output logic [NB_DATA-1:0]  mem_data_write_o,
    output logic [NB_DATA-1:0]  load_data_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                misaligned_o
);
    state_t             state, state_next;
    logic               accept, bad;
    logic               req_unsigned_q, misaligned_q;
    logic [1:0]         req_size_q, req_off_q;
    logic [NB_DATA-1:0] req_wdata_q, merged, load_ext;
    logic               unused_addr;
    assign unused_addr = ^req_addr_i[NB_BADDR-1:NB_WADDR+2];
    assign accept = req_valid_i && (state == S_IDLE || state == S_DONE);
    assign bad = is_misaligned(req_size_i, req_addr_i[1:0]);
    mem_lane_align #(.NB_DATA(NB_DATA)) u_align (
        .rd_word     (mem_data_i),
        .wdata       (req_wdata_q),
        .offset      (req_off_q),
        .size        (req_size_q),
        .is_unsigned (req_unsigned_q),
        .merged      (merged),
        .load_ext    (load_ext)
    );
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: state_next = !req_valid_i ? S_IDLE :
                                         bad ? S_DONE :
                                         !req_write_i ? S_RD :
                                         (req_size_i == SIZE_WORD) ? S_WR : S_RMW_RD;
            S_RD, S_WR, S_RMW_WR: state_next = S_DONE;
            S_RMW_RD: state_next = S_RMW_WR;
            default: state_next = S_IDLE;
        endcase
    end
    // strobes decode straight from one-hot state flops, so they are stable across the memory's negedge
    always_comb begin
        enable_mem_o = state inside {S_RD, S_WR, S_RMW_RD, S_RMW_WR};
        mem_read_o = state inside {S_RD, S_RMW_RD};
        mem_write_o = state inside {S_WR, S_RMW_WR};
        busy_o = enable_mem_o;
        done_o = state == S_DONE;
        misaligned_o = done_o && misaligned_q;
    end
    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_unsigned_q <= 1'b0;
            misaligned_q <= 1'b0;
            req_size_q <= '0;
            req_off_q <= '0;
            req_wdata_q <= '0;
            mem_addr_o <= '0;
            mem_data_write_o <= '0;
            load_data_o <= '0;
        end else begin
            if (accept) begin
                req_unsigned_q <= req_unsigned_i;
                misaligned_q <= bad;
                req_size_q <= req_size_i;
                req_off_q <= req_addr_i[1:0];
                req_wdata_q <= req_wdata_i;
                mem_addr_o <= req_addr_i[NB_WADDR+1:2];
                if (!bad && req_write_i && req_size_i == SIZE_WORD) mem_data_write_o <= req_wdata_i;
            end
            if (state == S_RD) load_data_o <= load_ext;
            if (state == S_RMW_RD) mem_data_write_o <= merged;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench with a negedge-sampling word memory model
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;
    typedef struct { logic mis; logic [31:0] data; } exp_t;
    typedef struct { logic [6:0] a; logic [31:0] d; } wr_t;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0, req_write = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [31:0] mem_rdata = 0;
    logic        enable_mem, mem_read, mem_write, busy, done, misaligned;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, load_data;
    logic [31:0] mem [128];
    logic [31:0] shadow [128];
    logic [31:0] last_load = 0;
    exp_t        exp_q[$];
    wr_t         wr_q[$];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clock_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .mem_data_i(mem_rdata),
        .enable_mem_o(enable_mem), .mem_read_o(mem_read), .mem_write_o(mem_write),
        .mem_addr_o(mem_addr), .mem_data_write_o(mem_wdata), .load_data_o(load_data),
        .busy_o(busy), .done_o(done), .misaligned_o(misaligned)
    );

    always @(negedge clk) begin
        if (enable_mem) begin
            mem_rdata <= mem_read ? mem[mem_addr] : 'z;
            if (mem_write) mem[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (enable_mem && mem_write) begin
            wr_t w;
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none expected", mem_addr, mem_wdata);
            end else begin
                w = wr_q.pop_front();
                if (mem_addr !== w.a || mem_wdata !== w.d) begin
                    errors++;
                    $display("FAIL write: addr=%0d data=%h, expected addr=%0d data=%h", mem_addr, mem_wdata, w.a, w.d);
                end
            end
        end
        if (done) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: no request outstanding");
            end else begin
                e = exp_q.pop_front();
                if (misaligned !== e.mis || load_data !== e.data) begin
                    errors++;
                    $display("FAIL done_result: mis=%b load=%h, expected mis=%b load=%h", misaligned, load_data, e.mis, e.data);
                end
            end
        end
    end

    function automatic logic ref_bad(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'b00: return 1'b0;
            2'b01: return lo[0];
            2'b11: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off, input logic [1:0] sz, input logic u);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00: return u ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01: return u ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] off, input logic [1:0] sz);
        logic [31:0] r;
        r = w;
        case (sz)
            2'b00: r[8*off +: 8] = d[7:0];
            2'b01: r[16*off[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
        logic       bad;
        logic [6:0] wa;
        int lat, n, rd_cnt, en_cnt, bz_cnt, wr_at, exp_rd;
        bad = ref_bad(sz, a[1:0]);
        wa = a[8:2];
        lat = bad ? 1 : (w && sz != SIZE_WORD) ? 3 : 2;
        exp_rd = (bad || (w && sz == SIZE_WORD)) ? 0 : 1;
        if (bad) exp_q.push_back('{1'b1, last_load});
        else if (!w) begin
            last_load = ref_load(shadow[wa], a[1:0], sz, u);
            exp_q.push_back('{1'b0, last_load});
        end else begin
            shadow[wa] = ref_merge(shadow[wa], d, a[1:0], sz);
            wr_q.push_back('{wa, shadow[wa]});
            exp_q.push_back('{1'b0, last_load});
        end
        @(posedge clk); #1;
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 0; req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        n = 1; rd_cnt = 0; en_cnt = 0; bz_cnt = 0; wr_at = 0;
        while (!done && n < 8) begin
            rd_cnt += int'(mem_read);
            en_cnt += int'(enable_mem);
            bz_cnt += int'(busy);
            if (mem_write) wr_at = n;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!done || n != lat) begin
            errors++;
            $display("FAIL latency a=%h sz=%0d w=%b: done at cycle %0d (done=%b), expected %0d", a, sz, w, n, done, lat);
        end
        checks++;
        if (rd_cnt != exp_rd || en_cnt != lat - 1 || bz_cnt != lat - 1) begin
            errors++;
            $display("FAIL strobes a=%h: reads=%0d en=%0d busy=%0d, expected reads=%0d en/busy=%0d", a, rd_cnt, en_cnt, bz_cnt, exp_rd, lat - 1);
        end
        if (w && !bad) begin
            checks++;
            if (wr_at != lat - 1) begin
                errors++;
                $display("FAIL write_cycle a=%h: write at cycle %0d, expected %0d", a, wr_at, lat - 1);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({enable_mem, mem_read, mem_write, busy, done, misaligned} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: %b, expected 000000", {enable_mem, mem_read, mem_write, busy, done, misaligned});
        end
        checks++;
        if (mem_addr !== 7'd0 || mem_wdata !== 32'd0 || load_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h load=%h, expected zeros", mem_addr, mem_wdata, load_data);
        end
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, enable_mem} !== 3'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done/en=%b, expected 000", {busy, done, enable_mem});
        end
    endtask

    task automatic test_loads;
        do_req(0, SIZE_WORD, 0, 32'h0, 0);
        checks++;
        if (load_data !== 32'h80000005) begin errors++; $display("FAIL lw0: %h, expected 80000005", load_data); end
        do_req(0, SIZE_BYTE, 0, 32'h3, 0);
        checks++;
        if (load_data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb3: %h, expected FFFFFF80", load_data); end
        do_req(0, SIZE_BYTE, 1, 32'h3, 0);
        checks++;
        if (load_data !== 32'h00000080) begin errors++; $display("FAIL lbu3: %h, expected 00000080", load_data); end
        do_req(0, SIZE_HALF, 0, 32'h0, 0);
        checks++;
        if (load_data !== 32'h00000005) begin errors++; $display("FAIL lh0: %h, expected 00000005", load_data); end
        for (int s = 0; s < 4; s++)
            for (int o = 0; o < 4; o++)
                for (int u = 0; u < 2; u++)
                    do_req(0, 2'(s), 1'(u), 32'h0C + 32'(o), 0);
        do_req(0, SIZE_WORD, 0, 32'h20C, 0);
        do_req(0, SIZE_HALF, 0, 32'hFFFFFE0E, 0);
    endtask

    task automatic test_subword_store;
        do_req(1, SIZE_BYTE, 0, 32'h5, 32'h000000AB);
        checks++;
        if (mem[1] !== 32'h00F0AB01) begin errors++; $display("FAIL sb5_mem: %h, expected 00F0AB01", mem[1]); end
        do_req(0, SIZE_WORD, 0, 32'h4, 0);
        checks++;
        if (load_data !== 32'h00F0AB01) begin errors++; $display("FAIL lw4: %h, expected 00F0AB01", load_data); end
        for (int o = 0; o < 4; o++) do_req(1, SIZE_BYTE, 0, 32'h10 + 32'(o), $urandom);
        do_req(1, SIZE_HALF, 0, 32'h12, $urandom);
        do_req(1, SIZE_HALF, 0, 32'h10, $urandom);
        do_req(1, SIZE_WORD, 0, 32'h14, $urandom);
        do_req(0, SIZE_WORD, 0, 32'h10, 0);
        do_req(0, SIZE_WORD, 0, 32'h14, 0);
    endtask

    task automatic test_misaligned;
        do_req(1, SIZE_HALF, 0, 32'h3, 32'h0000BEEF);
        do_req(1, SIZE_WORD, 0, 32'h2, 32'hDEADBEEF);
        checks++;
        if (mem[0] !== 32'h80000005) begin errors++; $display("FAIL misaligned_mem: %h, expected 80000005", mem[0]); end
    endtask

    task automatic test_reset_midop;
        @(posedge clk); #1;
        req_valid = 1; req_write = 1; req_size = SIZE_BYTE; req_unsigned = 0; req_addr = 32'h1; req_wdata = 32'hFF;
        @(posedge clk); #1;
        req_valid = 0;
        checks++;
        if (mem_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmw_rd_phase: read=%b busy=%b, expected 1 1", mem_read, busy);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({enable_mem, mem_read, mem_write, busy, done, misaligned} !== 6'b0 || mem_wdata !== 32'd0 || load_data !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: ctrl=%b wdata=%h load=%h, expected zeros",
                     {enable_mem, mem_read, mem_write, busy, done, misaligned}, mem_wdata, load_data);
        end
        last_load = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        do_req(0, SIZE_WORD, 0, 32'h0, 0);
        checks++;
        if (load_data !== 32'h80000005) begin errors++; $display("FAIL lw0_after_reset: %h, expected 80000005", load_data); end
    endtask

    task automatic test_back_to_back;
        shadow[2] = 32'h12345678;
        wr_q.push_back('{7'd2, 32'h12345678});
        exp_q.push_back('{1'b0, last_load});
        last_load = 32'h12345678;
        exp_q.push_back('{1'b0, 32'h12345678});
        @(posedge clk); #1;
        req_valid = 1; req_write = 1; req_size = SIZE_WORD; req_unsigned = 0; req_addr = 32'h8; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_sw_done: %b, expected 1", done); end
        req_write = 0;
        @(posedge clk); #1;
        req_valid = 0;
        checks++;
        if (done !== 1'b0 || mem_read !== 1'b1) begin
            errors++;
            $display("FAIL b2b_lw_rd: done=%b read=%b, expected 0 1", done, mem_read);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b1 || load_data !== 32'h12345678) begin
            errors++;
            $display("FAIL b2b_lw_done: done=%b load=%h, expected 1 12345678", done, load_data);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5AA5A5;
            shadow[i] = mem[i];
        end
        mem[0] = 32'h80000005; shadow[0] = mem[0];
        mem[1] = 32'h00F00301; shadow[1] = mem[1];
        mem[3] = 32'hC3827F41; shadow[3] = mem[3];
        test_reset;
        test_loads;
        test_subword_store;
        test_misaligned;
        test_reset_midop;
        test_back_to_back;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results and %0d writes outstanding", exp_q.size(), wr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
